// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle FSM control unit for the MIPS-subset CPU
module mc_control #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 4,
  parameter int CNTW   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [OPW-1:0]    op,
  input  logic [4:0]        rt,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_write,
  output logic              i_or_d,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              branch_not,
  output logic [1:0]        pc_source,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic              ext_op,
  output logic [1:0]        bhw,
  output logic              load_signed,
  output logic [1:0]        reg_dst,
  output logic [1:0]        mem_to_reg,
  output logic              reg_write,
  output logic              illegal,
  output logic [CNTW-1:0]   retired,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ITYPE  = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_REGIM = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b000011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_BLEZ  = OPW'(6'b000110);
  localparam logic [OPW-1:0] OP_BGTZ  = OPW'(6'b000111);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'b001001);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);
  localparam logic [OPW-1:0] OP_SLTIU = OPW'(6'b001011);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_XORI  = OPW'(6'b001110);
  localparam logic [OPW-1:0] OP_LUI   = OPW'(6'b001111);
  localparam logic [OPW-1:0] OP_LB    = OPW'(6'b100000);
  localparam logic [OPW-1:0] OP_LH    = OPW'(6'b100001);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_LBU   = OPW'(6'b100100);
  localparam logic [OPW-1:0] OP_LHU   = OPW'(6'b100101);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

  localparam logic [ALUOPW-1:0] ALU_ADD   = ALUOPW'(4'd0);
  localparam logic [ALUOPW-1:0] ALU_SUB   = ALUOPW'(4'd1);
  localparam logic [ALUOPW-1:0] ALU_FUNCT = ALUOPW'(4'd2);
  localparam logic [ALUOPW-1:0] ALU_AND   = ALUOPW'(4'd3);
  localparam logic [ALUOPW-1:0] ALU_OR    = ALUOPW'(4'd4);
  localparam logic [ALUOPW-1:0] ALU_XOR   = ALUOPW'(4'd5);
  localparam logic [ALUOPW-1:0] ALU_LUI   = ALUOPW'(4'd6);
  localparam logic [ALUOPW-1:0] ALU_SLT   = ALUOPW'(4'd7);
  localparam logic [ALUOPW-1:0] ALU_SLTU  = ALUOPW'(4'd8);
  localparam logic [ALUOPW-1:0] ALU_SGT   = ALUOPW'(4'd9);

  state_t          state_q, state_d;
  logic [CNTW-1:0] retired_q, retired_d;
  // Cleared by reset and set on the first edge afterwards; keeps every output
  // (including mem_req) low until the first clock edge after reset release.
  logic            active_q;
  logic            retire;

  assign retired = retired_q;
  assign state   = state_q;

  // State, activity flag and retirement counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_FETCH;
      active_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= 1'b1;
      retired_q <= retired_d;
    end
  end

  // Next-state sequencing and retirement detection.
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    if (active_q) begin
      unique case (state_q)
        S_FETCH:  if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          if (op == OP_RTYPE)
            state_d = S_EXEC;
          else if (op == OP_LB || op == OP_LH || op == OP_LW ||
                   op == OP_LBU || op == OP_LHU || op == OP_SW)
            state_d = S_MEMADR;
          else if (op == OP_BEQ || op == OP_BNE || op == OP_BLEZ || op == OP_BGTZ ||
                   (op == OP_REGIM && (rt == 5'd0 || rt == 5'd1)))
            state_d = S_BRANCH;
          else if (op == OP_J || op == OP_JAL)
            state_d = S_JUMP;
          else if (op >= OP_ADDI && op <= OP_LUI)
            state_d = S_ITYPE;
          else
            state_d = S_TRAP;
        end
        S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
        S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
        S_MEMWR:  if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
        S_EXEC:   state_d = S_RWB;
        S_RWB:    begin state_d = S_FETCH; retire = 1'b1; end
        S_ITYPE:  state_d = S_IWB;
        S_IWB:    begin state_d = S_FETCH; retire = 1'b1; end
        S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
        S_JUMP:   begin state_d = S_FETCH; retire = 1'b1; end
        S_TRAP:   state_d = S_FETCH;
        default:  state_d = S_FETCH;
      endcase
    end
    retired_d = retired_q + (retire ? CNTW'(1) : CNTW'(0));
  end

  // Control outputs decoded from the current state and the IR opcode.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_not    = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    ext_op        = 1'b0;
    bhw           = 2'b00;
    load_signed   = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    if (active_q) begin
      unique case (state_q)
        S_FETCH: begin
          // PC+4 is computed every FETCH cycle but only committed on ready.
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_op    = 1'b1;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
          case (op)
            OP_LB:   begin bhw = 2'b01; load_signed = 1'b1; end
            OP_LBU:  bhw = 2'b01;
            OP_LH:   begin bhw = 2'b10; load_signed = 1'b1; end
            OP_LHU:  bhw = 2'b10;
            default: bhw = 2'b00;
          endcase
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        S_ITYPE: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_op    = !(op == OP_ANDI || op == OP_ORI || op == OP_XORI);
          case (op)
            OP_SLTI:  alu_op = ALU_SLT;
            OP_SLTIU: alu_op = ALU_SLTU;
            OP_ANDI:  alu_op = ALU_AND;
            OP_ORI:   alu_op = ALU_OR;
            OP_XORI:  alu_op = ALU_XOR;
            OP_LUI:   alu_op = ALU_LUI;
            default:  alu_op = ALU_ADD;
          endcase
        end
        S_IWB: reg_write = 1'b1;
        S_BRANCH: begin
          // The ALU yields zero when the compare holds; branch_not flips the sense.
          alu_src_a     = 1'b1;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          case (op)
            OP_BEQ:  alu_op = ALU_SUB;
            OP_BNE:  begin alu_op = ALU_SUB; branch_not = 1'b1; end
            OP_BGTZ: begin alu_op = ALU_SGT; branch_not = 1'b1; end
            OP_BLEZ: alu_op = ALU_SGT;
            default: begin alu_op = ALU_SLT; branch_not = (rt == 5'd0); end
          endcase
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          if (op == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
        end
        S_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - randomized self-checking bench for mc_control
module tb_mc_control;

  logic       clk;
  logic       rstn;
  logic [5:0] op;
  logic [4:0] rt;
  logic       mem_ready;

  logic       mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_not;
  logic [1:0] pc_source, alu_src_b, bhw, reg_dst, mem_to_reg;
  logic       alu_src_a, ext_op, load_signed, reg_write, illegal;
  logic [3:0] alu_op, state;
  logic [31:0] retired;

  logic       d4_mem_req, d4_mem_write, d4_i_or_d, d4_ir_write, d4_pc_write, d4_pc_write_cond;
  logic       d4_branch_not, d4_alu_src_a, d4_ext_op, d4_load_signed, d4_reg_write, d4_illegal;
  logic [1:0] d4_pc_source, d4_alu_src_b, d4_bhw, d4_reg_dst, d4_mem_to_reg;
  logic [3:0] d4_alu_op, d4_state, d4_retired;

  int n_total = 0;
  int n_bad   = 0;
  int model_ret = 0;

  mc_control dut (
    .clk(clk), .rstn(rstn), .op(op), .rt(rt), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_not(branch_not),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ext_op(ext_op), .bhw(bhw), .load_signed(load_signed), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
    .retired(retired), .state(state)
  );

  mc_control #(.CNTW(4)) dut4 (
    .clk(clk), .rstn(rstn), .op(op), .rt(rt), .mem_ready(mem_ready),
    .mem_req(d4_mem_req), .mem_write(d4_mem_write), .i_or_d(d4_i_or_d), .ir_write(d4_ir_write),
    .pc_write(d4_pc_write), .pc_write_cond(d4_pc_write_cond), .branch_not(d4_branch_not),
    .pc_source(d4_pc_source), .alu_src_a(d4_alu_src_a), .alu_src_b(d4_alu_src_b),
    .alu_op(d4_alu_op), .ext_op(d4_ext_op), .bhw(d4_bhw), .load_signed(d4_load_signed),
    .reg_dst(d4_reg_dst), .mem_to_reg(d4_mem_to_reg), .reg_write(d4_reg_write),
    .illegal(d4_illegal), .retired(d4_retired), .state(d4_state)
  );

  logic [25:0] ctrl_vec, ctrl4_vec;
  assign ctrl_vec = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_not,
                     pc_source, alu_src_a, alu_src_b, alu_op, ext_op, bhw, load_signed,
                     reg_dst, mem_to_reg, reg_write, illegal};
  assign ctrl4_vec = {d4_mem_req, d4_mem_write, d4_i_or_d, d4_ir_write, d4_pc_write,
                      d4_pc_write_cond, d4_branch_not, d4_pc_source, d4_alu_src_a, d4_alu_src_b,
                      d4_alu_op, d4_ext_op, d4_bhw, d4_load_signed, d4_reg_dst, d4_mem_to_reg,
                      d4_reg_write, d4_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t op=%b rt=%0d)", tag, got, exp, $time, op, rt);
    end
  endtask

  // Expected control word for one cycle, taken from the per-state behaviour of the unit.
  function automatic logic [25:0] exp_ctrl(int s, logic [5:0] o, logic [4:0] r, logic rdy);
    logic mreq = 0, mwr = 0, iod = 0, irw = 0, pcw = 0, pcwc = 0, bn = 0, asa = 0;
    logic ext = 0, ls = 0, rw = 0, ill = 0;
    logic [1:0] ps = 0, asb = 0, bh = 0, rd = 0, m2r = 0;
    logic [3:0] aop = 0;
    case (s)
      0: begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1: asb = 2'b11;
      2: begin asa = 1; asb = 2'b10; ext = 1; end
      3: begin mreq = 1; iod = 1; end
      4: begin
        rw = 1; m2r = 2'b01;
        if (o == 6'b100000) begin bh = 2'b01; ls = 1; end
        if (o == 6'b100100) bh = 2'b01;
        if (o == 6'b100001) begin bh = 2'b10; ls = 1; end
        if (o == 6'b100101) bh = 2'b10;
      end
      5: begin mreq = 1; mwr = 1; iod = 1; end
      6: begin asa = 1; aop = 4'd2; end
      7: begin rw = 1; rd = 2'b01; end
      8: begin
        asa = 1; pcwc = 1; ps = 2'b01;
        if (o == 6'b000100) aop = 4'd1;
        else if (o == 6'b000101) begin aop = 4'd1; bn = 1; end
        else if (o == 6'b000111) begin aop = 4'd9; bn = 1; end
        else if (o == 6'b000110) aop = 4'd9;
        else begin aop = 4'd7; bn = (r == 5'd0); end
      end
      9: begin
        pcw = 1; ps = 2'b10;
        if (o == 6'b000011) begin rw = 1; rd = 2'b10; m2r = 2'b10; end
      end
      10: begin
        asa = 1; asb = 2'b10;
        ext = !(o == 6'b001100 || o == 6'b001101 || o == 6'b001110);
        case (o)
          6'b001010: aop = 4'd7;
          6'b001011: aop = 4'd8;
          6'b001100: aop = 4'd3;
          6'b001101: aop = 4'd4;
          6'b001110: aop = 4'd5;
          6'b001111: aop = 4'd6;
          default:   aop = 4'd0;
        endcase
      end
      11: rw = 1;
      12: ill = 1;
      default: ;
    endcase
    return {mreq, mwr, iod, irw, pcw, pcwc, bn, ps, asa, asb, aop, ext, bh, ls, rd, m2r, rw, ill};
  endfunction

  // Runs one instruction from FETCH; waits<0 gives random memory stalls, else that
  // many stalls in the data-memory state and none in FETCH. Called at a negedge.
  task automatic run_instr(input logic [5:0] o, input logic [4:0] r, input int waits);
    int path[6];
    int n;
    int k;
    int w;
    int s;
    logic rdy;
    if (o == 6'd0) begin path = '{0, 1, 6, 7, 0, 0}; n = 4; end
    else if (o == 6'd32 || o == 6'd33 || o == 6'd35 || o == 6'd36 || o == 6'd37)
      begin path = '{0, 1, 2, 3, 4, 0}; n = 5; end
    else if (o == 6'd43) begin path = '{0, 1, 2, 5, 0, 0}; n = 4; end
    else if ((o >= 6'd4 && o <= 6'd7) || (o == 6'd1 && r <= 5'd1))
      begin path = '{0, 1, 8, 0, 0, 0}; n = 3; end
    else if (o == 6'd2 || o == 6'd3) begin path = '{0, 1, 9, 0, 0, 0}; n = 3; end
    else if (o >= 6'd8 && o <= 6'd15) begin path = '{0, 1, 10, 11, 0, 0}; n = 4; end
    else begin path = '{0, 1, 12, 0, 0, 0}; n = 3; end
    op = o;
    rt = r;
    k = 0;
    w = 0;
    while (k < n) begin
      s = path[k];
      if (s == 3 || s == 5)
        rdy = (waits >= 0) ? (w >= waits) : (w >= 3 || $urandom_range(0, 2) != 0);
      else if (s == 0)
        rdy = (waits >= 0) ? 1'b1 : (w >= 3 || $urandom_range(0, 2) != 0);
      else
        rdy = 1'($urandom_range(0, 1));
      mem_ready = rdy;
      #1;
      chk("state", {28'd0, state}, s);
      chk("ctrl", {6'd0, ctrl_vec}, {6'd0, exp_ctrl(s, o, r, rdy)});
      chk("retired", retired, model_ret);
      chk("ctrl4", {6'd0, ctrl4_vec}, {6'd0, exp_ctrl(s, o, r, rdy)});
      chk("retired4", {28'd0, d4_retired}, model_ret % 16);
      @(negedge clk);
      if (rdy || !(s == 0 || s == 3 || s == 5)) begin
        if (s == 4 || s == 5 || s == 7 || s == 8 || s == 9 || s == 11) model_ret++;
        k++;
        w = 0;
      end else begin
        w++;
      end
    end
  endtask

  logic [5:0] legal_ops [22];
  int base;

  initial begin
    legal_ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
                  6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd43};
    rstn = 1'b0;
    op = 6'd0;
    rt = 5'd0;
    mem_ready = 1'b1;
    #1;
    chk("rst_state", {28'd0, state}, 0);
    chk("rst_ctrl", {6'd0, ctrl_vec}, 0);
    chk("rst_retired", retired, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rel_mem_req", {31'd0, mem_req}, 0);
    @(negedge clk);

    // Directed instructions from the plan.
    run_instr(6'b000000, 5'd0, 0);   // add
    run_instr(6'b100101, 5'd0, 3);   // lhu with 3 stalls
    run_instr(6'b000001, 5'd1, 0);   // bgez
    run_instr(6'b000011, 5'd0, 0);   // jal
    base = model_ret;
    run_instr(6'b111111, 5'd0, 0);   // illegal
    chk("trap_noretire", retired, base);
    run_instr(6'b000001, 5'd7, 0);   // regimm with bad rt
    run_instr(6'b101011, 5'd0, 2);   // sw with stalls

    // Sixteen retirements return the 4-bit counter to where it started.
    base = model_ret;
    for (int i = 0; i < 16; i++) run_instr(6'b001000, 5'd0, 0);
    chk("wrap4", {28'd0, d4_retired}, base % 16);
    chk("wrap32", retired, base + 16);

    // Reset in MEMRD while waiting on memory.
    op = 6'b100011;
    rt = 5'd0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_state", {28'd0, state}, 3);
    chk("pre_rst_mem_req", {31'd0, mem_req}, 1);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_state", {28'd0, state}, 0);
    chk("mid_rst_mem_req", {31'd0, mem_req}, 0);
    chk("mid_rst_retired", retired, 0);
    chk("mid_rst_ctrl", {6'd0, ctrl_vec}, 0);
    chk("mid_rst_retired4", {28'd0, d4_retired}, 0);
    model_ret = 0;
    mem_ready = 1'b1;
    @(negedge clk);
    #2 rstn = 1'b1;
    #1;
    chk("post_rel_mem_req", {31'd0, mem_req}, 0);
    chk("post_rel_state", {28'd0, state}, 0);
    @(negedge clk);

    // Randomized instruction mix with random stalls and ignored mem_ready.
    for (int i = 0; i < 60; i++) begin
      logic [5:0] o;
      logic [4:0] r;
      if ($urandom_range(0, 9) < 7) o = legal_ops[$urandom_range(0, 21)];
      else o = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 2))
        0: r = 5'd0;
        1: r = 5'd1;
        default: r = 5'($urandom_range(0, 31));
      endcase
      run_instr(o, r, -1);
    end
    #1;
    chk("final_state", {28'd0, state}, 0);
    chk("final_retired", retired, model_ret);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the MIPS-subset CPU. It replaces the single-cycle opcode decoder with a registered finite state machine that sequences fetch, decode, execute, memory and write-back over several cycles, and stalls on a ready/request memory handshake. It flags illegal opcodes through a trap state and counts retired instructions. It sits between the instruction register and the shared datapath: ALU, register file, PC, unified memory port and extenders.

## Interface
- `OPW`, 6: opcode width.
- `ALUOPW`, 4: width of `alu_op`.
- `CNTW`, 32: width of the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `op` in OPW: IR[31:26].
- `rt` in 5: IR[20:16], selects bgez/bltz.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access in progress.
- `mem_write` out 1: access is a write (valid only with `mem_req`).
- `i_or_d` out 1: 0 selects the PC as address, 1 selects the ALUOut register.
- `ir_write` out 1: load the IR.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if the branch condition holds.
- `branch_not` out 1: invert the zero flag for the branch test.
- `pc_source` out 2: 00 ALU, 01 ALUOut, 10 jump target.
- `alu_src_a` out 1: 0 selects PC, 1 selects rs.
- `alu_src_b` out 2: 00 rt, 01 constant 4, 10 extended immediate, 11 immediate shifted left by 2.
- `alu_op` out ALUOPW: ALU function.
- `ext_op` out 1: 1 selects sign-extension.
- `bhw` out 2: load size, 00 word, 01 byte, 10 half.
- `load_signed` out 1: sign-extend a byte or half load.
- `reg_dst` out 2: 00 rt, 01 rd, 10 register 31.
- `mem_to_reg` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `reg_write` out 1: register-file write enable.
- `illegal` out 1: pulses in TRAP.
- `retired` out CNTW: count of completed instructions.
- `state` out 4: current state, for debug.

## Operation
- alu_op encoding:
  - 0000 ADD
  - 0001 SUB
  - 0010 FUNCT (decode the funct field)
  - 0011 AND
  - 0100 OR
  - 0101 XOR
  - 0110 LUI
  - 0111 SLT
  - 1000 SLTU
  - 1001 SGT
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7
  - BRANCH=8, JUMP=9, ITYPE=10, IWB=11, TRAP=12
- FETCH: `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD, `pc_source`=00.
  - `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1; the FSM then goes to DECODE.
  - While `mem_ready`=0 the FSM holds in FETCH with both strobes at 0.
- DECODE: computes the branch target (`alu_src_a`=0, `alu_src_b`=11, ADD), then dispatches on `op`:
  - 000000 → EXEC
  - 100000, 100001, 100011, 100100, 100101, 101011 → MEMADR
  - 000100, 000101, 000110, 000111, and 000001 with `rt` ∈ {00000, 00001} → BRANCH
  - 000010, 000011 → JUMP
  - 001000 through 001111 → ITYPE
  - anything else, including 000001 with another `rt` → TRAP
- MEMADR: rs + sign-extended immediate. Goes to MEMWR for 101011, otherwise MEMRD.
- MEMRD: `mem_req`=1, `i_or_d`=1; waits on `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=01, `reg_dst`=00.
  - lb: `bhw`=01, `load_signed`=1. lbu: `bhw`=01, `load_signed`=0.
  - lh: `bhw`=10, `load_signed`=1. lhu: `bhw`=10, `load_signed`=0.
  - lw: `bhw`=00.
- MEMWR: `mem_req`=1, `mem_write`=1, `i_or_d`=1; waits on `mem_ready`, then goes to FETCH.
- EXEC: rs op rt with `alu_op`=FUNCT, then RWB. RWB: `reg_write`=1, `reg_dst`=01.
- ITYPE: `alu_src_b`=10. `ext_op`=0 for andi, ori and xori; 1 otherwise. `alu_op` by opcode:
  - addi/addiu: ADD
  - slti: SLT; sltiu: SLTU
  - andi: AND; ori: OR; xori: XOR
  - lui: LUI
  - Then IWB: `reg_write`=1, `reg_dst`=00.
- BRANCH: `pc_write_cond`=1, `pc_source`=01.
  - beq: SUB, `branch_not`=0.
  - bne: SUB, `branch_not`=1.
  - bgtz: SGT against zero, `branch_not`=1.
  - blez: SGT, `branch_not`=0.
  - bltz: SLT against zero, `branch_not`=1.
  - bgez: SLT, `branch_not`=0.
  - The ALU sets result=0 when the compare is true.
- JUMP: `pc_write`=1, `pc_source`=10. For jal, additionally `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10; the PC already holds PC+4.
- TRAP: `illegal`=1 for one cycle, then FETCH. No register or memory write; the instruction does not retire.
- Any output not listed for a state is 0.
- `retired` increments by 1 on exit from MEMWB, MEMWR, RWB, IWB, BRANCH and JUMP. It wraps modulo 2^CNTW.

## Timing
- State, `retired` and every registered control output update on the rising edge of `clk`.
- Asynchronous reset (`rstn`=0), including mid-instruction or mid-wait:
  - `state` returns to FETCH and `retired` clears to 0.
  - All outputs are forced to 0, including `mem_req`.
  - The first access request follows the first `clk` edge after `rstn` rises.
- With `mem_ready` tied to 1, CPI is:
  - lw/lb/lh: 5
  - sw, R-type, I-type: 4
  - branch, jump: 3
  - illegal opcode: 3
- Each wait cycle at a memory state adds one cycle. `mem_req` stays high and the address-select outputs stay stable until the ready cycle.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.

## Test plan
- Reset asserted in MEMRD with `mem_ready`=0 → immediately `state`=0, `mem_req`=0, `retired`=0. After release, FETCH requests on the next edge.
- add (op 000000), `mem_ready`=1 → states 0,1,6,7,0. `reg_write`=1 only in state 7, with `reg_dst`=01. `retired` goes 0→1.
- lhu with `mem_ready` low for 3 cycles in MEMRD → 8 cycles total. MEMWB shows `bhw`=10, `load_signed`=0, `mem_to_reg`=01.
- bgez (op 000001, rt 00001) → BRANCH with `alu_op`=0111, `branch_not`=0, `pc_write_cond`=1. Finishes in 3 cycles.
- jal → JUMP with `pc_write`=1, `pc_source`=10, `reg_dst`=10, `mem_to_reg`=10, `reg_write`=1.
- op 111111 → TRAP, `illegal` pulses once, `retired` unchanged. Separately, with `CNTW`=4, 16 retirements wrap the counter to 0.
